// File: rtl/link_pkg.sv
// ============================================================================
// Module      : link_pkg
// Description : Shared frame layout, FSM encodings and helpers for the
//               car-control <-> simulated-device UART link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package link_pkg;

    localparam logic [1:0] FRAME_HDR   = 2'b10;

    localparam int         BIT_DESTROY = 5;
    localparam int         BIT_PLACE   = 4;
    localparam int         MOVE_MSB    = 3;
    localparam int         MOVE_LSB    = 0;

    localparam int         DET_FRONT   = 0;
    localparam int         DET_LEFT    = 1;
    localparam int         DET_RIGHT   = 2;
    localparam int         DET_BACK    = 3;
    localparam logic [3:0] DET_SAFE    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } link_state_e;

    typedef enum logic [1:0] {
        BCN_NONE    = 2'd0,
        BCN_PLACE   = 2'd1,
        BCN_DESTROY = 2'd2
    } beacon_e;

    function automatic logic [7:0] build_frame(input logic       destroy,
                                               input logic       place,
                                               input logic [3:0] mv);
        build_frame = {FRAME_HDR, destroy, place, mv};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_watchdog.sv
// ============================================================================
// Module      : rx_watchdog
// Description : Latches received detector nibbles and declares the link lost
//               after RX_TIMEOUT cycles without a received byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_watchdog
    import link_pkg::*;
#(
    parameter int RX_TIMEOUT = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [3:0] o_detector,
    output logic       o_link_ok
);

    localparam int             CW         = $clog2(RX_TIMEOUT + 1);
    localparam logic [CW-1:0]  c_timeout  = CW'(RX_TIMEOUT);
    localparam logic [CW-1:0]  c_to_last  = CW'(RX_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_detector;
    logic          r_link_ok;
    logic          w_unused_rx_hi;

    assign w_unused_rx_hi = ^i_rx_data[7:4];

    // Counter parks at the timeout value, so the loss edge fires only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_detector <= DET_SAFE;
            r_link_ok  <= 1'b0;
        end else if (i_rx_valid) begin
            r_cnt      <= '0;
            r_detector <= i_rx_data[DET_BACK:DET_FRONT];
            r_link_ok  <= 1'b1;
        end else if (r_cnt != c_timeout) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == c_to_last) begin
                r_link_ok  <= 1'b0;
                r_detector <= DET_SAFE;
            end
        end
    end

    assign o_detector = r_detector;
    assign o_link_ok  = r_link_ok;

endmodule

`default_nettype wire

// File: rtl/device_link_ctrl.sv
// ============================================================================
// Module      : device_link_ctrl
// Description : Builds and schedules command frames (periodic / on change),
//               stretches beacon requests over several frames, and hosts the
//               receive-side detector latch and link watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module device_link_ctrl
    import link_pkg::*;
#(
    parameter int FRAME_PERIOD = 100_000,
    parameter int MIN_GAP      = 1_000,
    parameter int BEACON_HOLD  = 2,
    parameter int RX_TIMEOUT   = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       i_power,
    input  logic [3:0] i_move_cmd,
    input  logic       i_place_req,
    input  logic       i_destroy_req,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [3:0] o_detector,
    output logic       o_link_ok,
    output logic       o_place_pending,
    output logic       o_destroy_pending
);

    localparam int            PW          = $clog2(FRAME_PERIOD + 1);
    localparam int            GW          = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int            HW          = $clog2(BEACON_HOLD + 1);
    localparam logic [PW-1:0] c_period    = PW'(FRAME_PERIOD);
    localparam logic [GW-1:0] c_gap_last  = GW'(MIN_GAP - 1);
    localparam logic [HW-1:0] c_hold_init = HW'(BEACON_HOLD);

    link_state_e   r_state;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic [3:0]    r_last_move;
    logic [PW-1:0] r_period_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_place_pend;
    logic          r_destroy_pend;
    beacon_e       r_act;
    logic [HW-1:0] r_hold;

    logic [3:0]    w_eff_move;
    logic          w_place_pend;
    logic          w_destroy_pend;
    beacon_e       w_act;
    beacon_e       w_new_act;
    logic          w_trigger;
    logic          w_handshake;

    // Without power every beacon request is void, even before its flag clears.
    assign w_eff_move     = i_power ? i_move_cmd : 4'b0000;
    assign w_place_pend   = r_place_pend & i_power;
    assign w_destroy_pend = r_destroy_pend & i_power;
    assign w_act          = i_power ? r_act : BCN_NONE;

    assign w_new_act = (w_act != BCN_NONE) ? w_act :
                       w_place_pend        ? BCN_PLACE :
                       w_destroy_pend      ? BCN_DESTROY : BCN_NONE;

    assign w_trigger   = (r_period_cnt == c_period) | (w_eff_move != r_last_move)
                       | w_place_pend | w_destroy_pend;
    assign w_handshake = r_tx_valid & i_tx_ready;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_tx_data      <= build_frame(1'b0, 1'b0, 4'b0000);
            r_tx_valid     <= 1'b0;
            r_last_move    <= 4'b0000;
            r_period_cnt   <= '0;
            r_gap_cnt      <= '0;
            r_place_pend   <= 1'b0;
            r_destroy_pend <= 1'b0;
            r_act          <= BCN_NONE;
            r_hold         <= '0;
        end else begin
            if (w_handshake) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt != c_period) begin
                r_period_cnt <= r_period_cnt + PW'(1);
            end

            if (!i_power) begin
                r_place_pend   <= 1'b0;
                r_destroy_pend <= 1'b0;
                r_act          <= BCN_NONE;
                r_hold         <= '0;
            end else begin
                if (i_place_req && !r_place_pend) begin
                    r_place_pend <= 1'b1;
                end
                if (i_destroy_req && !r_destroy_pend) begin
                    r_destroy_pend <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_tx_data  <= build_frame(w_new_act == BCN_DESTROY,
                                                  w_new_act == BCN_PLACE, w_eff_move);
                        r_tx_valid <= 1'b1;
                        r_state    <= SEND;
                        if ((w_act == BCN_NONE) && (w_new_act != BCN_NONE)) begin
                            r_act  <= w_new_act;
                            r_hold <= c_hold_init;
                        end
                    end
                end
                SEND: begin
                    if (w_handshake) begin
                        r_tx_valid  <= 1'b0;
                        r_last_move <= r_tx_data[MOVE_MSB:MOVE_LSB];
                        r_gap_cnt   <= '0;
                        r_state     <= GAP;
                        if (w_act != BCN_NONE) begin
                            r_hold <= r_hold - HW'(1);
                            // Last frame of the hold retires the request.
                            if (r_hold == HW'(1)) begin
                                r_act <= BCN_NONE;
                                if (w_act == BCN_PLACE) begin
                                    r_place_pend <= 1'b0;
                                end else begin
                                    r_destroy_pend <= 1'b0;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_data         = r_tx_data;
    assign o_tx_valid        = r_tx_valid;
    assign o_place_pending   = r_place_pend;
    assign o_destroy_pending = r_destroy_pend;

    rx_watchdog #(
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx_watchdog (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_detector (o_detector),
        .o_link_ok  (o_link_ok)
    );

endmodule

`default_nettype wire

// File: tb/tb_device_link_ctrl.sv
// ============================================================================
// Module      : tb_device_link_ctrl
// Description : Directed + randomized bench for device_link_ctrl with a
//               timestamp-based behavioural model of the link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_device_link_ctrl;

    localparam int FP = 40;
    localparam int MG = 5;
    localparam int BH = 2;
    localparam int RT = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       power;
    logic [3:0] move;
    logic       place;
    logic       destroy;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic [3:0] o_detector;
    logic       o_link_ok;
    logic       o_place_pending;
    logic       o_destroy_pending;

    always #5 clk = ~clk;

    device_link_ctrl #(
        .FRAME_PERIOD (FP),
        .MIN_GAP      (MG),
        .BEACON_HOLD  (BH),
        .RX_TIMEOUT   (RT)
    ) dut (
        .sys_clk           (clk),
        .rst_n             (rst_n),
        .i_power           (power),
        .i_move_cmd        (move),
        .i_place_req       (place),
        .i_destroy_req     (destroy),
        .o_tx_data         (o_tx_data),
        .o_tx_valid        (o_tx_valid),
        .i_tx_ready        (tx_ready),
        .i_rx_data         (rx_data),
        .i_rx_valid        (rx_valid),
        .o_detector        (o_detector),
        .o_link_ok         (o_link_ok),
        .o_place_pending   (o_place_pending),
        .o_destroy_pending (o_destroy_pending)
    );

    int checks = 0;
    int fails  = 0;
    bit checking = 1'b0;

    // Model state: time is the number of clock edges seen ("cur").
    int         cur;
    int         m_ref;        // edge at which the period age restarted
    int         m_idle_from;  // first edge index at which a new frame may be scheduled
    bit         m_valid;
    logic [7:0] m_frame;
    logic [3:0] m_last;
    bit         m_pp, m_dp;
    int         m_act;        // 0 none, 1 place, 2 destroy
    int         m_hold;
    bit         m_have_rx;
    int         m_rx_at;
    logic [3:0] m_rx_nib;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s: got %02h expected %02h (edge %0d)", name, act, exp, cur);
        end
    endtask

    task automatic model_reset();
        m_valid     = 1'b0;
        m_frame     = 8'h80;
        m_last      = 4'h0;
        m_pp        = 1'b0;
        m_dp        = 1'b0;
        m_act       = 0;
        m_hold      = 0;
        m_have_rx   = 1'b0;
        m_rx_at     = 0;
        m_rx_nib    = 4'h0;
        m_ref       = cur;
        m_idle_from = cur;
    endtask

    task automatic model_step();
        int         nxt;
        bit         idle, hs, pp, dp, set_p, set_d;
        int         act, a;
        logic [3:0] eff;
        nxt = cur + 1;
        if (!rst_n) begin
            cur = nxt;
            model_reset();
            return;
        end
        idle  = !m_valid && (cur >= m_idle_from);
        hs    = m_valid && tx_ready;
        eff   = power ? move : 4'h0;
        pp    = m_pp && power;
        dp    = m_dp && power;
        act   = power ? m_act : 0;
        set_p = power && place && !m_pp;
        set_d = power && destroy && !m_dp;
        if (rx_valid) begin
            m_have_rx = 1'b1;
            m_rx_at   = nxt;
            m_rx_nib  = rx_data[3:0];
        end
        if (idle && ((cur - m_ref) >= FP || eff != m_last || pp || dp)) begin
            a = act;
            if (a == 0) a = pp ? 1 : (dp ? 2 : 0);
            if (act == 0 && a != 0) begin
                m_act  = a;
                m_hold = BH;
            end
            m_frame = 8'h80 | ((a == 2) ? 8'h20 : 8'h00) | ((a == 1) ? 8'h10 : 8'h00) | {4'h0, eff};
            m_valid = 1'b1;
        end
        if (hs) begin
            m_last      = m_frame[3:0];
            m_ref       = nxt;
            m_valid     = 1'b0;
            m_idle_from = nxt + MG;
            if (act != 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    if (act == 1) m_pp = 1'b0;
                    else          m_dp = 1'b0;
                    m_act = 0;
                end
            end
        end
        if (set_p) m_pp = 1'b1;
        if (set_d) m_dp = 1'b1;
        if (!power) begin
            m_pp = 1'b0; m_dp = 1'b0; m_act = 0; m_hold = 0;
        end
        cur = nxt;
    endtask

    function automatic bit exp_link();
        return m_have_rx && ((cur - m_rx_at) < RT);
    endfunction

    function automatic bit model_quiet();
        return !m_valid && (cur >= m_idle_from) && (m_last == (power ? move : 4'h0))
               && !m_pp && !m_dp;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("tx_valid",        o_tx_valid,        m_valid);
            chk("tx_data",         o_tx_data,         m_frame);
            chk("link_ok",         o_link_ok,         exp_link());
            chk("detector",        o_detector,        exp_link() ? m_rx_nib : 4'hF);
            chk("place_pending",   o_place_pending,   m_pp);
            chk("destroy_pending", o_destroy_pending, m_dp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (!model_quiet() && n < 300) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_hs(output logic [7:0] d);
        int n = 0;
        while (!(o_tx_valid && tx_ready) && n < 300) begin
            cyc();
            n++;
        end
        chk("hs_seen", o_tx_valid & tx_ready, 1'b1);
        d = o_tx_data;
        cyc();
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] exp_seq [4];
        int         n;
        exp_seq[0] = 8'h91; exp_seq[1] = 8'h91; exp_seq[2] = 8'hA1; exp_seq[3] = 8'hA1;

        rst_n = 1'b0; power = 1'b0; move = 4'h0; place = 1'b0; destroy = 1'b0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        cur = 0;
        model_reset();
        cyc();
        checking = 1'b1;
        cyc();
        chk("rst_tx_data",  o_tx_data,  8'h80);
        chk("rst_tx_valid", o_tx_valid, 1'b0);
        chk("rst_detector", o_detector, 4'hF);
        chk("rst_link_ok",  o_link_ok,  1'b0);
        rst_n = 1'b1;

        // Periodic resend from a cold start.
        n = 0;
        while (!o_tx_valid && n < FP + 10) begin
            cyc();
            n++;
        end
        chk("first_frame_latency", n[7:0], FP + 1);
        chk("idle_frame", o_tx_data, 8'h80);

        // Move change and the minimum gap.
        drain();
        power = 1'b1; move = 4'h5;
        cyc();
        chk("move_frame_valid", o_tx_valid, 1'b1);
        chk("move_frame", o_tx_data, 8'h85);
        cyc();
        move = 4'h6;
        for (int i = 0; i < MG; i++) begin
            cyc();
            chk("gap_quiet", o_tx_valid, 1'b0);
        end
        cyc();
        chk("after_gap_frame", o_tx_data, 8'h86);
        move = 4'h1;
        drain();

        // Simultaneous beacons.
        place = 1'b1; destroy = 1'b1;
        cyc();
        place = 1'b0; destroy = 1'b0;
        chk("both_pending", {o_place_pending, o_destroy_pending}, 2'b11);
        for (int k = 0; k < 4; k++) begin
            wait_hs(d);
            chk("beacon_frame", d, exp_seq[k]);
            if (k == 1) chk("place_cleared", {o_place_pending, o_destroy_pending}, 2'b01);
            if (k == 3) chk("destroy_cleared", {o_place_pending, o_destroy_pending}, 2'b00);
        end

        // Power off.
        drain();
        power = 1'b0; move = 4'h8; place = 1'b1;
        cyc();
        place = 1'b0;
        chk("off_no_pending", o_place_pending, 1'b0);
        wait_hs(d);
        chk("off_frame", d, 8'h80);

        // Backpressure.
        power = 1'b1;
        drain();
        tx_ready = 1'b0; move = 4'h3;
        cyc(); cyc();
        chk("bp_first", o_tx_data, 8'h83);
        for (int i = 0; i < 50; i++) begin
            move = 4'($urandom);
            cyc();
        end
        chk("bp_stable", o_tx_data, 8'h83);
        move = 4'h9; tx_ready = 1'b1;
        wait_hs(d);
        n = 0;
        while (!o_tx_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("bp_gap_latency", n[7:0], MG + 1);
        chk("bp_new_frame", o_tx_data, 8'h89);

        // Asynchronous reset in the middle of SEND.
        wait_hs(d);
        tx_ready = 1'b0; move = 4'h4;
        n = 0;
        while (!o_tx_valid && n < 50) begin
            cyc();
            n++;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", o_tx_valid, 1'b0);
        cyc(); cyc();
        rst_n = 1'b1; tx_ready = 1'b1;

        // Receive path and watchdog boundary.
        rx_valid = 1'b1; rx_data = 8'h06;
        cyc();
        rx_valid = 1'b0;
        chk("rx_detector", o_detector, 4'h6);
        chk("rx_link_ok", o_link_ok, 1'b1);
        repeat (RT - 1) cyc();
        chk("wd_before_timeout", o_link_ok, 1'b1);
        cyc();
        chk("wd_link_lost", o_link_ok, 1'b0);
        chk("wd_detector_safe", o_detector, 4'hF);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            power    = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) move = 4'($urandom);
            place    = ($urandom_range(0, 29) == 0);
            destroy  = ($urandom_range(0, 29) == 0);
            tx_ready = ($urandom_range(0, 9) < 7);
            rx_valid = ($urandom_range(0, 59) == 0);
            rx_data  = 8'($urandom);
            cyc();
        end
        place = 1'b0; destroy = 1'b0; rx_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
